// File: rtl/complex_demux_pack_ctrl.sv
// complex_demux_pack_ctrl
// Sequencing controller for the complex N-to-2N demux datapath. Pairs of
// half vectors (NI/2 complex elements each) arriving on a ready/valid stream
// are placed into the low and then the high half of a registered full vector
// (NI elements), which is presented on a ready/valid output.
//
// Ports:
//   clk         in   rising-edge clock
//   rst_n       in   asynchronous active-low reset
//   clr         in   synchronous clear, discards any partial or held vector
//   in_valid    in   half vector valid
//   in_ready    out  half vector can be accepted (combinational on out_ready)
//   in_data     in   half vector, ELEMENT_WIDTH*NI/2 bits
//   in_last     in   half vector closes a group (flushes a lone low half)
//   sel         out  demux select: 0 = low half next, 1 = high half next
//   out_valid   out  full vector valid
//   out_ready   in   consumer accepts the full vector
//   out_data    out  registered full vector, low half in the low bits
//   out_partial out  out_data holds a low half only, high half is zero
//   vec_count   out  completed output handshakes, wraps modulo 2^CNT_WIDTH
module complex_demux_pack_ctrl #(
  parameter int NI            = 8,
  parameter int ELEMENT_WIDTH = 64,
  parameter int CNT_WIDTH     = 16
) (
  input  logic                            clk,
  input  logic                            rst_n,
  input  logic                            clr,
  input  logic                            in_valid,
  output logic                            in_ready,
  input  logic [ELEMENT_WIDTH*NI/2-1:0]   in_data,
  input  logic                            in_last,
  output logic                            sel,
  output logic                            out_valid,
  input  logic                            out_ready,
  output logic [ELEMENT_WIDTH*NI-1:0]     out_data,
  output logic                            out_partial,
  output logic [CNT_WIDTH-1:0]            vec_count
);

  localparam int HW = ELEMENT_WIDTH * NI / 2;
  localparam int FW = 2 * HW;

  typedef enum logic [1:0] {
    ST_EMPTY = 2'd0,
    ST_HALF  = 2'd1,
    ST_FULL  = 2'd2
  } state_t;

  state_t                 r_state;
  logic                   r_out_valid;
  logic                   r_sel;
  logic                   r_partial;
  logic [FW-1:0]          r_data;
  logic [CNT_WIDTH-1:0]   r_vec_count;

  logic                   w_in_ready;
  logic                   w_accept;
  logic                   w_out_hs;
  state_t                 w_low_state;
  state_t                 w_nxt_state;
  logic                   w_nxt_partial;
  logic [FW-1:0]          w_nxt_data;

  // A presented vector blocks the input unless it is leaving this same cycle.
  assign w_in_ready = ~r_out_valid | out_ready;
  assign w_accept   = in_valid & w_in_ready;
  assign w_out_hs   = r_out_valid & out_ready;

  // A lone low half tagged last is flushed straight out as a partial vector.
  assign w_low_state = in_last ? ST_FULL : ST_HALF;

  // Next-state and next-vector selection; clr overrides everything.
  always_comb begin
    w_nxt_state   = r_state;
    w_nxt_partial = r_partial;
    w_nxt_data    = r_data;
    if (clr) begin
      w_nxt_state   = ST_EMPTY;
      w_nxt_partial = 1'b0;
      w_nxt_data    = {FW{1'b0}};
    end else begin
      case (r_state)
        ST_EMPTY: begin
          if (w_accept) begin
            w_nxt_state   = w_low_state;
            w_nxt_partial = in_last;
            w_nxt_data    = {{HW{1'b0}}, in_data};
          end else begin
            w_nxt_state   = r_state;
          end
        end
        ST_HALF: begin
          // in_last is irrelevant here: the pair is complete either way.
          if (w_accept) begin
            w_nxt_state   = ST_FULL;
            w_nxt_partial = 1'b0;
            w_nxt_data    = {in_data, r_data[HW-1:0]};
          end else begin
            w_nxt_state   = r_state;
          end
        end
        ST_FULL: begin
          if (w_out_hs) begin
            if (w_accept) begin
              w_nxt_state   = w_low_state;
              w_nxt_partial = in_last;
              w_nxt_data    = {{HW{1'b0}}, in_data};
            end else begin
              w_nxt_state   = ST_EMPTY;
            end
          end else begin
            w_nxt_state   = r_state;
          end
        end
        default: begin
          w_nxt_state   = ST_EMPTY;
          w_nxt_partial = 1'b0;
          w_nxt_data    = {FW{1'b0}};
        end
      endcase
    end
  end

  // State, registered status flags, vector storage and handshake counter.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state     <= ST_EMPTY;
      r_out_valid <= 1'b0;
      r_sel       <= 1'b0;
      r_partial   <= 1'b0;
      r_data      <= {FW{1'b0}};
      r_vec_count <= {CNT_WIDTH{1'b0}};
    end else begin
      r_state     <= w_nxt_state;
      r_out_valid <= (w_nxt_state == ST_FULL);
      r_sel       <= (w_nxt_state == ST_HALF);
      r_partial   <= w_nxt_partial;
      r_data      <= w_nxt_data;
      // A handshake completing in a clr cycle still counts.
      if (w_out_hs) begin
        r_vec_count <= r_vec_count + CNT_WIDTH'(1);
      end else begin
        r_vec_count <= r_vec_count;
      end
    end
  end

  assign in_ready    = w_in_ready;
  assign sel         = r_sel;
  assign out_valid   = r_out_valid;
  assign out_partial = r_partial;
  assign out_data    = r_data;
  assign vec_count   = r_vec_count;

endmodule
